// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared flit layout, TX FSM states and counter helpers for the
//               NoC processing-element endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int unsigned MAX_FLIT_W = 256;
    localparam int unsigned MAX_CNT_W  = 64;

    localparam int unsigned ADDR_X_LSB = 0;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

    function automatic int unsigned addr_y_lsb(input int unsigned x_size);
        return ADDR_X_LSB + x_size;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned x_size,
                                             input int unsigned y_size);
        return ADDR_X_LSB + x_size + y_size;
    endfunction

    function automatic logic [MAX_FLIT_W-1:0] flit_pack(
        input int unsigned           x_size,
        input int unsigned           y_size,
        input logic [MAX_FLIT_W-1:0] dest_x,
        input logic [MAX_FLIT_W-1:0] dest_y,
        input logic [MAX_FLIT_W-1:0] data
    );
        return (data   << data_lsb(x_size, y_size)) |
               (dest_y << addr_y_lsb(x_size))       |
               (dest_x << ADDR_X_LSB);
    endfunction

    function automatic logic [MAX_FLIT_W-1:0] flit_field(
        input logic [MAX_FLIT_W-1:0] flit,
        input int unsigned           lsb,
        input int unsigned           width
    );
        return (flit >> lsb) & ~({MAX_FLIT_W{1'b1}} << width);
    endfunction

    // Add 0..3 to a counter of the given width, clamping at all-ones.
    function automatic logic [MAX_CNT_W-1:0] sat_add(
        input logic [MAX_CNT_W-1:0] cnt,
        input logic [1:0]           inc,
        input int unsigned          width
    );
        logic [MAX_CNT_W:0] sum;
        logic [MAX_CNT_W:0] lim;
        lim = {(MAX_CNT_W+1){1'b1}} >> (MAX_CNT_W + 1 - width);
        sum = {1'b0, cnt} + {{(MAX_CNT_W-1){1'b0}}, inc};
        return (sum > lim) ? lim[MAX_CNT_W-1:0] : sum[MAX_CNT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_pe_endpoint_if.sv
// ============================================================================
// Module      : noc_pe_endpoint_if
// Description : Host TX/RX and switch local-port signals of one PE endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_pe_endpoint_if #(
    parameter int x_size     = 1,
    parameter int y_size     = 1,
    parameter int data_width = 32,
    parameter int CNT_W      = 16
);
    localparam int total_width = x_size + y_size + data_width;

    logic                   tx_valid;
    logic                   tx_ready;
    logic [x_size-1:0]      tx_dest_x;
    logic [y_size-1:0]      tx_dest_y;
    logic [data_width-1:0]  tx_data;

    logic                   o_valid_noc;
    logic                   i_ready_noc;
    logic [total_width-1:0] o_data_noc;
    logic                   i_valid_noc;
    logic [total_width-1:0] i_data_noc;

    logic                   rx_valid;
    logic                   rx_ready;
    logic [data_width-1:0]  rx_data;
    logic [CNT_W-1:0]       drop_cnt;
    logic [CNT_W-1:0]       err_cnt;

    // Endpoint side
    modport master (
        input  tx_valid, tx_dest_x, tx_dest_y, tx_data,
        output tx_ready,
        output o_valid_noc, o_data_noc,
        input  i_ready_noc, i_valid_noc, i_data_noc,
        output rx_valid, rx_data,
        input  rx_ready,
        output drop_cnt, err_cnt
    );

    // Host plus switch side
    modport slave (
        output tx_valid, tx_dest_x, tx_dest_y, tx_data,
        input  tx_ready,
        input  o_valid_noc, o_data_noc,
        output i_ready_noc, i_valid_noc, i_data_noc,
        input  rx_valid, rx_data,
        output rx_ready,
        input  drop_cnt, err_cnt
    );

endinterface

`default_nettype wire

// File: rtl/noc_sync_fifo.sv
// ============================================================================
// Module      : noc_sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers; head is shown
//               combinationally on dout_o. A push while full is accepted
//               only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [WIDTH-1:0] din_i,
    output logic      [WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/noc_pe_endpoint.sv
// ============================================================================
// Module      : noc_pe_endpoint
// Description : PE-side endpoint of a switch local port: TX flit packing with
//               a valid/ready output stage, RX buffering with drop/error stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_pe_endpoint
    import noc_pkg::*;
#(
    parameter int X           = 2,
    parameter int Y           = 2,
    parameter int x_coord     = 0,
    parameter int y_coord     = 0,
    parameter int data_width  = 32,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int total_width = x_size + y_size + data_width,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int CNT_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    noc_pe_endpoint_if.master  bus
);

    localparam logic [x_size-1:0] C_X = x_size'(x_coord);
    localparam logic [y_size-1:0] C_Y = y_size'(y_coord);

    // Async assert, synchronous release of the internal reset
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_q <= 2'b00;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------ TX
    logic                   tx_full;
    logic                   tx_empty;
    logic                   tx_accept;
    logic                   tx_bad;
    logic                   tx_push;
    logic                   tx_pop;
    logic [total_width-1:0] tx_flit;
    logic [total_width-1:0] tx_head;

    assign bus.tx_ready = !tx_full;
    assign tx_accept    = bus.tx_valid && !tx_full;
    assign tx_bad       = tx_accept &&
                          ((32'(bus.tx_dest_x) >= 32'(X)) ||
                           (32'(bus.tx_dest_y) >= 32'(Y)));
    assign tx_push      = tx_accept && !tx_bad;
    assign tx_flit      = total_width'(flit_pack(x_size, y_size,
                                                 MAX_FLIT_W'(bus.tx_dest_x),
                                                 MAX_FLIT_W'(bus.tx_dest_y),
                                                 MAX_FLIT_W'(bus.tx_data)));

    noc_sync_fifo #(
        .WIDTH (total_width),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .din_i   (tx_flit),
        .dout_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    tx_state_e              state_q;
    logic                   valid_q;
    logic [total_width-1:0] data_q;

    // Reload whenever the stage is empty or its flit is being taken
    assign tx_pop = !tx_empty && ((state_q == TX_IDLE) || bus.i_ready_noc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        data_q  <= tx_head;
                        valid_q <= 1'b1;
                        state_q <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    if (bus.i_ready_noc) begin
                        if (!tx_empty) begin
                            data_q <= tx_head;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.o_valid_noc = valid_q;
    assign bus.o_data_noc  = data_q;

    // ------------------------------------------------------------------ RX
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_pop;
    logic                  rx_push;
    logic                  rx_drop;
    logic                  rx_misroute;
    logic [x_size-1:0]     rx_dx;
    logic [y_size-1:0]     rx_dy;
    logic [data_width-1:0] rx_payload;

    assign rx_dx      = x_size'(flit_field(MAX_FLIT_W'(bus.i_data_noc),
                                           ADDR_X_LSB, x_size));
    assign rx_dy      = y_size'(flit_field(MAX_FLIT_W'(bus.i_data_noc),
                                           addr_y_lsb(x_size), y_size));
    assign rx_payload = data_width'(flit_field(MAX_FLIT_W'(bus.i_data_noc),
                                               data_lsb(x_size, y_size),
                                               data_width));

    assign rx_pop      = !rx_empty && bus.rx_ready;
    assign rx_push     = bus.i_valid_noc && (!rx_full || rx_pop);
    assign rx_drop     = bus.i_valid_noc && !rx_push;
    assign rx_misroute = bus.i_valid_noc && ((rx_dx != C_X) || (rx_dy != C_Y));

    noc_sync_fifo #(
        .WIDTH (data_width),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .din_i   (rx_payload),
        .dout_o  (bus.rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign bus.rx_valid = !rx_empty;

    // ------------------------------------------------------------ counters
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_d;
    logic [1:0]       err_inc;

    assign err_inc = {1'b0, tx_bad} + {1'b0, rx_misroute};
    assign err_d   = CNT_W'(sat_add(MAX_CNT_W'(err_q), err_inc, CNT_W));
    assign drop_d  = CNT_W'(sat_add(MAX_CNT_W'(drop_q), {1'b0, rx_drop}, CNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            drop_q <= '0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign bus.err_cnt  = err_q;
    assign bus.drop_cnt = drop_q;

endmodule

`default_nettype wire

// File: doc/noc_pe_endpoint.md
Name: noc_pe_endpoint

Overview:
- PE-side endpoint of one mesh/torus switch's local port. It is the counterpart of the switch's PE interface.
- TX path: packs host messages into flits and drives them into the switch with a valid/ready handshake.
- RX path: the switch's delivery port has no backpressure, so the RX path accepts every delivered flit into a buffer, drops on overflow and counts drops.
- One instance sits between each PE and its switch.

Parameters:
- X, 2, mesh columns
- Y, 2, mesh rows
- x_coord, 0, this endpoint's column
- y_coord, 0, this endpoint's row
- data_width, 32, payload bits
- x_size, 1, X-address bits
- y_size, 1, Y-address bits
- total_width, x_size+y_size+data_width, flit width
- TX_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 4, RX FIFO entries (power of two, ≥2)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- tx_valid  in  1  host message valid
- tx_ready  out  1  TX FIFO can accept
- tx_dest_x  in  x_size  destination column
- tx_dest_y  in  y_size  destination row
- tx_data  in  data_width  payload
- o_valid_noc  out  1  flit valid to switch i_valid_pe
- i_ready_noc  in  1  switch o_ready_pe
- o_data_noc  out  total_width  flit to switch i_data_pe
- i_valid_noc  in  1  switch o_valid_pe
- i_data_noc  in  total_width  switch o_data_pe
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  host pops RX
- rx_data  out  data_width  received payload
- drop_cnt  out  CNT_W  RX overflow drops
- err_cnt  out  CNT_W  bad destination on TX plus misrouted RX flits

Behaviour:
- Reset (async assert, sync deassert internally): all FIFOs empty; o_valid_noc=0, o_data_noc=0, rx_valid=0, drop_cnt=0, err_cnt=0, tx_ready=1. Flits in flight are lost.
- Flit format:
  - bits [x_size-1:0] = dest x
  - bits [x_size+y_size-1:x_size] = dest y
  - bits [total_width-1:x_size+y_size] = data
- TX accept:
  - tx_ready = !tx_full. It is registered-state only, with no combinational path from i_ready_noc.
  - Push occurs on tx_valid&tx_ready.
  - If tx_dest_x≥X or tx_dest_y≥Y, the message is consumed but not written, and err_cnt increments.
  - Self-addressed messages are legal and are sent.
- TX output stage, 2-state FSM:
  - IDLE: o_valid_noc=0. If the FIFO is non-empty, pop into the output register and go to HOLD.
  - HOLD: o_valid_noc=1 and o_data_noc is stable. On i_ready_noc=1, the transfer completes. If the FIFO is non-empty, reload in the same cycle and stay in HOLD (back-to-back, 1 flit/cycle); otherwise go to IDLE.
  - o_valid_noc never drops without i_ready_noc.
- TX latency: tx push at cycle N → o_valid_noc at N+2 if the FIFO and stage were empty.
- RX:
  - Every cycle with i_valid_noc=1, the payload is written if RX is not full, or if it is full while rx_valid&rx_ready pops that same cycle.
  - Otherwise the flit is dropped and drop_cnt increments.
  - Latency from i_valid_noc to rx_valid is 1 cycle. rx_data is the FIFO head, valid while rx_valid.
- Misroute check: if the received address field ≠ (x_coord,y_coord), err_cnt increments and the flit is still stored.
- Counters saturate at all-ones and never wrap.
- A TX-error and an RX-misroute in the same cycle add 2, saturating.
- FIFO pointers are log2(DEPTH)+1 bits. Full/empty come from a pointer MSB compare, and pointers wrap naturally.

Decomposition:
- Shared package noc_pkg:
  - flit field offsets (ADDR_X_LSB, ADDR_Y_LSB, DATA_LSB)
  - pack/unpack functions
  - saturating-increment function
- One sub-module, noc_sync_fifo (WIDTH, DEPTH, push/pop/full/empty/dout). It is instantiated for TX (total_width) and RX (data_width).
- Top-level size: FSM, counters and glue in ~250 lines.

Test Plan:
All tests use X=Y=2, x_size=y_size=1, data_width=32, coords (1,0).
- Single send: tx dest (0,1) data 0xDEADBEEF, i_ready_noc=1 → o_valid_noc 2 cycles later with o_data_noc={32'hDEADBEEF,1'b1,1'b0} for exactly 1 cycle.
- Backpressure: push 5 flits with i_ready_noc=0 → tx_ready falls after 4 FIFO entries plus 1 held flit; o_data_noc stays stable. Releasing ready gives 5 flits in order on consecutive cycles.
- Bad destination: tx_dest_x=1 with X=1 build (X=1, x_size=1) → no flit emitted, err_cnt=1.
- RX burst overflow: 6 consecutive i_valid_noc addressed (1,0) with rx_ready=0 → 4 stored, drop_cnt=2. Then popping returns payloads 0..3 in order.
- Full with simultaneous pop: RX full, i_valid_noc=1 with rx_ready=1 same cycle → no drop, occupancy stays 4.
- Misroute plus reset: deliver a flit addressed (0,0) → err_cnt=1 and the payload is still readable. Asserting rstn=0 mid-HOLD drops o_valid_noc and clears all counters immediately.
